// File: rtl/pipeline_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl_pkg
// Description : Shared forwarding codes, memory-FSM state encoding and the
//               operand forwarding selector used by the hazard controller.
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_hazard_ctrl_pkg;

    localparam logic [1:0] c_fwd_rf   = 2'd0;
    localparam logic [1:0] c_fwd_ealu = 2'd1;
    localparam logic [1:0] c_fwd_malu = 2'd2;
    localparam logic [1:0] c_fwd_mmo  = 2'd3;

    typedef enum logic [0:0] {
        c_st_idle = 1'b0,
        c_st_wait = 1'b1
    } dmem_state_t;

    // A load still in EX has no data yet, so only an ALU result in EX may forward.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] r,
        input logic       ewreg,
        input logic       em2reg,
        input logic [4:0] edest,
        input logic       mwreg,
        input logic       mm2reg,
        input logic [4:0] mdest
    );
        logic [1:0] v_sel;
        v_sel = c_fwd_rf;
        if (r == 5'd0) begin
            v_sel = c_fwd_rf;
        end else if (ewreg && !em2reg && (edest == r)) begin
            v_sel = c_fwd_ealu;
        end else if (mwreg && (mdest == r)) begin
            v_sel = mm2reg ? c_fwd_mmo : c_fwd_malu;
        end
        return v_sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl_if
// Description : Pipeline-side bundle of the hazard controller: hazard inputs,
//               data-memory handshake and register enables/flushes.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_use_rs;
    logic             id_use_rt;
    logic             ewreg;
    logic             em2reg;
    logic [4:0]       edestReg;
    logic             mwreg;
    logic             mm2reg;
    logic [4:0]       mdestReg;
    logic             branch_taken;
    logic             m_mem_access;
    logic             dmem_ready;
    logic             dmem_req;
    logic             pc_en;
    logic             ifid_en;
    logic             exmem_en;
    logic             memwb_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic             memwb_bubble;
    logic [1:0]       fwda;
    logic [1:0]       fwdb;
    logic             mem_err;
    logic [CNT_W-1:0] stall_count;

    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt,
        input  ewreg, em2reg, edestReg, mwreg, mm2reg, mdestReg,
        input  branch_taken, m_mem_access, dmem_ready,
        output dmem_req, pc_en, ifid_en, exmem_en, memwb_en,
        output ifid_flush, idex_flush, memwb_bubble, fwda, fwdb,
        output mem_err, stall_count
    );

    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt,
        output ewreg, em2reg, edestReg, mwreg, mm2reg, mdestReg,
        output branch_taken, m_mem_access, dmem_ready,
        input  dmem_req, pc_en, ifid_en, exmem_en, memwb_en,
        input  ifid_flush, idex_flush, memwb_bubble, fwda, fwdb,
        input  mem_err, stall_count
    );

endinterface
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_dmem_wait_fsm.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl_dmem_wait_fsm
// Description : Data-memory handshake FSM with bounded wait and sticky error.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl_dmem_wait_fsm
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  wire  clk,
    input  wire  rst,
    input  logic i_mem_access,
    input  logic i_ready,
    output logic o_dmem_req,
    output logic o_mem_stall,
    output logic o_timeout,
    output logic o_mem_err
);

    localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CW-1:0] c_last = CW'(MEM_TIMEOUT - 1);

    dmem_state_t   r_state;
    logic [CW-1:0] r_cnt;
    logic          r_mem_err;
    logic          w_idle;

    assign w_idle      = (r_state == c_st_idle);
    assign o_dmem_req  = (w_idle && i_mem_access) || !w_idle;
    assign o_mem_stall = (w_idle && i_mem_access && !i_ready) ||
                         (!w_idle && !i_ready && (r_cnt < c_last));
    // Final wait cycle without ready: the access is abandoned and the pipeline moves on.
    assign o_timeout   = !w_idle && !i_ready && (r_cnt == c_last);
    assign o_mem_err   = r_mem_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_st_idle;
            r_cnt     <= '0;
            r_mem_err <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (i_mem_access && !i_ready) begin
                        r_state <= c_st_wait;
                        r_cnt   <= '0;
                    end
                end
                c_st_wait: begin
                    if (i_ready) begin
                        r_state <= c_st_idle;
                    end else if (r_cnt == c_last) begin
                        r_state   <= c_st_idle;
                        r_mem_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl
// Description : 5-stage pipeline sequencer: load-use detection, ID operand
//               forwarding, branch squash and data-memory stall control.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  wire                    clock,
    input  wire                    reset,
    pipeline_hazard_ctrl_if.slave  bus
);

    logic             w_mem_stall;
    logic             w_timeout;
    logic             w_dmem_req;
    logic             w_mem_err;
    logic             w_rs_hit;
    logic             w_rt_hit;
    logic             w_load_use;
    logic             w_pc_en;
    logic             w_ifid_en;
    logic             w_exmem_en;
    logic             w_memwb_en;
    logic             w_ifid_flush;
    logic             w_idex_flush;
    logic [CNT_W-1:0] r_stall_count;

    pipeline_hazard_ctrl_dmem_wait_fsm #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_dmem_wait_fsm (
        .clk          (clock),
        .rst          (reset),
        .i_mem_access (bus.m_mem_access),
        .i_ready      (bus.dmem_ready),
        .o_dmem_req   (w_dmem_req),
        .o_mem_stall  (w_mem_stall),
        .o_timeout    (w_timeout),
        .o_mem_err    (w_mem_err)
    );

    assign w_rs_hit   = bus.id_use_rs && (bus.edestReg == bus.id_rs);
    assign w_rt_hit   = bus.id_use_rt && (bus.edestReg == bus.id_rt);
    assign w_load_use = bus.ewreg && bus.em2reg && (bus.edestReg != 5'd0) &&
                        (w_rs_hit || w_rt_hit);

    // Load-use beats a taken branch: the branch operand is not ready, so the flush waits.
    always_comb begin
        w_pc_en      = 1'b1;
        w_ifid_en    = 1'b1;
        w_exmem_en   = 1'b1;
        w_memwb_en   = 1'b1;
        w_ifid_flush = 1'b0;
        w_idex_flush = 1'b0;
        if (w_mem_stall) begin
            w_pc_en    = 1'b0;
            w_ifid_en  = 1'b0;
            w_exmem_en = 1'b0;
        end else if (w_load_use) begin
            w_pc_en      = 1'b0;
            w_ifid_en    = 1'b0;
            w_idex_flush = 1'b1;
        end else if (bus.branch_taken) begin
            w_ifid_flush = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_stall_count <= '0;
        end else if ((w_mem_stall || w_load_use) && (r_stall_count != '1)) begin
            r_stall_count <= r_stall_count + CNT_W'(1);
        end
    end

    assign bus.pc_en        = w_pc_en;
    assign bus.ifid_en      = w_ifid_en;
    assign bus.exmem_en     = w_exmem_en;
    assign bus.memwb_en     = w_memwb_en;
    assign bus.ifid_flush   = w_ifid_flush;
    assign bus.idex_flush   = w_idex_flush;
    assign bus.memwb_bubble = w_mem_stall || w_timeout;
    assign bus.dmem_req     = w_dmem_req;
    assign bus.mem_err      = w_mem_err;
    assign bus.stall_count  = r_stall_count;
    assign bus.fwda = fwd_sel(bus.id_rs, bus.ewreg, bus.em2reg, bus.edestReg,
                              bus.mwreg, bus.mm2reg, bus.mdestReg);
    assign bus.fwdb = fwd_sel(bus.id_rt, bus.ewreg, bus.em2reg, bus.edestReg,
                              bus.mwreg, bus.mm2reg, bus.mdestReg);

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_hazard_ctrl
// Description : Vector table, corner sequences and random stimulus against a
//               cycle-age reference model of the hazard controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_W       = 4;
    localparam int SAT         = (1 << CNT_W) - 1;

    logic clock = 1'b0;
    logic reset;

    pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipeline_hazard_ctrl #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [4:0] rs, rt;
        logic       urs, urt;
        logic       ew, em;
        logic [4:0] ed;
        logic       mw, mm;
        logic [4:0] md;
        logic       br, macc, rdy;
    } in_t;

    typedef struct {
        string       name;
        in_t         i;
        logic [11:0] exp;
    } vec_t;

    // {pc,ifid,exmem,memwb, ifid_flush,idex_flush,bubble,req, fwda, fwdb}
    logic [11:0] outs;
    assign outs = {bus.pc_en, bus.ifid_en, bus.exmem_en, bus.memwb_en,
                   bus.ifid_flush, bus.idex_flush, bus.memwb_bubble, bus.dmem_req,
                   bus.fwda, bus.fwdb};

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: cycles already spent on the outstanding access (0 = none).
    int age   = 0;
    bit m_err = 0;
    int m_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic in_t mk(input logic [4:0] rs, input logic [4:0] rt,
                               input logic urs, input logic urt,
                               input logic ew, input logic em, input logic [4:0] ed,
                               input logic mw, input logic mm, input logic [4:0] md,
                               input logic br, input logic macc, input logic rdy);
        in_t v;
        v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt;
        v.ew = ew; v.em = em; v.ed = ed;
        v.mw = mw; v.mm = mm; v.md = md;
        v.br = br; v.macc = macc; v.rdy = rdy;
        return v;
    endfunction

    function automatic logic [1:0] m_fwd(input logic [4:0] r, input in_t v);
        if (r == 5'd0) return 2'd0;
        if (v.ew && !v.em && v.ed == r) return 2'd1;
        if (v.mw && v.md == r) return v.mm ? 2'd3 : 2'd2;
        return 2'd0;
    endfunction

    function automatic bit m_active(input in_t v);
        return (age > 0) || v.macc;
    endfunction

    function automatic bit m_mstall(input in_t v);
        return m_active(v) && !v.rdy && (age < MEM_TIMEOUT);
    endfunction

    function automatic bit m_lu(input in_t v);
        return v.ew && v.em && (v.ed != 0) &&
               ((v.urs && v.ed == v.rs) || (v.urt && v.ed == v.rt));
    endfunction

    function automatic logic [11:0] m_outs(input in_t v);
        logic [3:0] en;
        logic fl_if, fl_ex, bub, tmo;
        tmo   = m_active(v) && !v.rdy && (age == MEM_TIMEOUT);
        en    = 4'b1111;
        fl_if = 1'b0;
        fl_ex = 1'b0;
        bub   = m_mstall(v) || tmo;
        if (m_mstall(v)) en = 4'b0001;
        else if (m_lu(v)) begin en = 4'b0011; fl_ex = 1'b1; end
        else if (v.br) fl_if = 1'b1;
        return {en, fl_if, fl_ex, bub, m_active(v), m_fwd(v.rs, v), m_fwd(v.rt, v)};
    endfunction

    task automatic m_step(input in_t v);
        bit st;
        st = m_mstall(v) || m_lu(v);
        if (st && m_cnt < SAT) m_cnt++;
        if (m_mstall(v)) age++;
        else begin
            if (m_active(v) && !v.rdy) m_err = 1;
            age = 0;
        end
    endtask

    task automatic drive(input in_t v);
        bus.id_rs = v.rs;   bus.id_rt = v.rt;
        bus.id_use_rs = v.urs; bus.id_use_rt = v.urt;
        bus.ewreg = v.ew;   bus.em2reg = v.em;  bus.edestReg = v.ed;
        bus.mwreg = v.mw;   bus.mm2reg = v.mm;  bus.mdestReg = v.md;
        bus.branch_taken = v.br;
        bus.m_mem_access = v.macc;
        bus.dmem_ready   = v.rdy;
    endtask

    // Called at posedge+1; checks mid-cycle and leaves at the next posedge+1.
    task automatic cycle(input string name, input in_t v, input bit use_exp, input logic [11:0] exp);
        logic [11:0] e;
        drive(v);
        #2;
        e = use_exp ? exp : m_outs(v);
        chk({name, ".outs"}, 32'(outs), 32'(e));
        chk({name, ".mem_err"}, 32'(bus.mem_err), 32'(m_err));
        chk({name, ".stall_count"}, 32'(bus.stall_count), 32'(m_cnt));
        m_step(v);
        @(posedge clock);
        #1;
    endtask

    vec_t tbl[$];

    task automatic add(input string n, input in_t i, input logic [11:0] e);
        vec_t x;
        x.name = n; x.i = i; x.exp = e;
        tbl.push_back(x);
    endtask

    initial begin
        in_t idle, v;
        int  sc0;

        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add("fwd_ex_rs",     mk(3, 0, 1, 0, 1, 0, 3, 0, 0, 0, 0, 0, 1), 12'b1111_0000_0100);
        add("fwd_r0",        mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1), 12'b1111_0000_0000);
        add("fwd_mem_alu",   mk(0, 7, 0, 1, 0, 0, 0, 1, 0, 7, 0, 0, 1), 12'b1111_0000_0010);
        add("fwd_mem_ld",    mk(0, 7, 0, 1, 0, 0, 0, 1, 1, 7, 0, 0, 1), 12'b1111_0000_0011);
        add("fwd_ex_prio",   mk(9, 0, 1, 0, 1, 0, 9, 1, 1, 9, 0, 0, 1), 12'b1111_0000_0100);
        add("lu_rs",         mk(9, 0, 1, 0, 1, 1, 9, 0, 0, 0, 0, 0, 1), 12'b0011_0100_0000);
        add("lu_no_use",     mk(9, 0, 0, 0, 1, 1, 9, 0, 0, 0, 0, 0, 1), 12'b1111_0000_0000);
        add("lu_r0",         mk(0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1), 12'b1111_0000_0000);
        add("branch",        mk(1, 2, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1), 12'b1111_1000_0000);
        add("br_lu",         mk(6, 0, 1, 0, 1, 1, 6, 0, 0, 0, 1, 0, 1), 12'b0011_0100_0000);
        add("mem_zero_lat",  mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1), 12'b1111_0001_0000);
        add("mem_br",        mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1), 12'b1111_1001_0000);
        add("lu_rt",         mk(0, 5, 0, 1, 1, 1, 5, 0, 0, 0, 0, 0, 1), 12'b0011_0100_0000);
        add("fwd_both",      mk(4, 4, 1, 1, 1, 0, 4, 1, 0, 4, 0, 0, 1), 12'b1111_0000_0101);
        add("ld_ex_mem_alu", mk(8, 0, 0, 0, 1, 1, 8, 1, 0, 8, 0, 0, 1), 12'b1111_0000_1000);

        // Reset state, checked while reset is still held.
        reset = 1'b1;
        drive(idle);
        #3;
        chk("reset.outs", 32'(outs), 32'(12'b1111_0000_0000));
        chk("reset.mem_err", 32'(bus.mem_err), 32'd0);
        chk("reset.stall_count", 32'(bus.stall_count), 32'd0);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;

        foreach (tbl[k]) cycle(tbl[k].name, tbl[k].i, 1'b1, tbl[k].exp);

        // Load-use, then the load sits in MEM and its data forwards.
        cycle("lu.a", mk(0, 5, 0, 1, 1, 1, 5, 0, 0, 0, 0, 0, 1), 1'b1, 12'b0011_0100_0000);
        cycle("lu.b", mk(0, 5, 0, 1, 0, 0, 0, 1, 1, 5, 0, 0, 1), 1'b1, 12'b1111_0000_0011);

        // Branch deferred behind load-use.
        cycle("brlu.a", mk(0, 5, 0, 1, 1, 1, 5, 0, 0, 0, 1, 0, 1), 1'b1, 12'b0011_0100_0000);
        cycle("brlu.b", mk(0, 5, 0, 1, 0, 0, 0, 1, 1, 5, 1, 0, 1), 1'b1, 12'b1111_1000_0011);

        // Store with ready low for three cycles.
        sc0 = m_cnt;
        v = idle; v.macc = 1'b1;
        for (int k = 0; k < 3; k++) cycle($sformatf("st.w%0d", k), v, 1'b1, 12'b0001_0011_0000);
        v.rdy = 1'b1;
        cycle("st.done", v, 1'b1, 12'b1111_0001_0000);
        chk("st.stall_delta", 32'(bus.stall_count), 32'(sc0 + 3));
        cycle("st.after", idle, 1'b1, 12'b1111_0000_0000);

        // Ready never arrives: MEM_TIMEOUT stall cycles, then one drop cycle.
        v = idle; v.macc = 1'b1;
        for (int k = 0; k < MEM_TIMEOUT; k++) cycle($sformatf("to.w%0d", k), v, 1'b1, 12'b0001_0011_0000);
        chk("to.err_before", 32'(bus.mem_err), 32'd0);
        cycle("to.drop", v, 1'b1, 12'b1111_0011_0000);
        chk("to.err_set", 32'(bus.mem_err), 32'd1);
        cycle("to.next", idle, 1'b1, 12'b1111_0000_0000);
        cycle("to.next2", idle, 1'b1, 12'b1111_0000_0000);
        chk("to.err_sticky", 32'(bus.mem_err), 32'd1);

        // Drive stall_count into saturation.
        for (int k = 0; k < 5; k++)
            cycle($sformatf("sat.%0d", k), mk(9, 0, 1, 0, 1, 1, 9, 0, 0, 0, 0, 0, 1), 1'b1, 12'b0011_0100_0000);
        chk("sat.value", 32'(bus.stall_count), 32'(SAT));

        for (int k = 0; k < 400; k++) begin
            v = mk(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   1'($urandom), 1'($urandom),
                   1'($urandom), 1'($urandom), 5'($urandom_range(0, 7)),
                   1'($urandom), 1'($urandom), 5'($urandom_range(0, 7)),
                   ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0), 1'($urandom));
            cycle($sformatf("rnd%0d", k), v, 1'b0, 12'd0);
        end

        // Reset in the middle of a wait: outputs recover without a clock edge.
        v = idle; v.macc = 1'b1;
        cycle("rst.a", v, 1'b1, 12'b0001_0011_0000);
        cycle("rst.b", v, 1'b1, 12'b0001_0011_0000);
        #1;
        reset = 1'b1;
        bus.m_mem_access = 1'b0;
        #1;
        chk("rst.dmem_req", 32'(bus.dmem_req), 32'd0);
        chk("rst.outs", 32'(outs), 32'(12'b1111_0000_0000));
        chk("rst.stall_count", 32'(bus.stall_count), 32'd0);
        chk("rst.mem_err", 32'(bus.mem_err), 32'd0);
        age = 0; m_err = 0; m_cnt = 0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        cycle("rst.after", idle, 1'b1, 12'b1111_0000_0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
